// File: rtl/rv32_fetch.sv
// Instruction fetch stage with IF/ID pipeline register for the 5-stage RV32 core.
// Issues one imem request at a time, buffers responses under stall and kills wrong-path fetches.
module rv32_fetch #(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        halt,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        busy,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    // Gated by rst_n so no request escapes while reset is held.
    assign imem_req  = rst_n && (state_q == StIdle) && !halt;
    assign imem_addr = pc;
    assign busy      = !deliver;

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        req_pc_d      = req_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        deliver       = 1'b0;
        deliver_pc    = req_pc_q;
        deliver_instr = imem_rdata;

        unique case (state_q)
            StIdle: begin
                // A flush here needs no kill: pc already holds the redirect target.
                if (imem_req && imem_gnt) begin
                    state_d  = StWait;
                    req_pc_d = pc;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = StIdle;
                    end else if (!stall) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        hold_pc_d    = req_pc_q;
                        hold_instr_d = imem_rdata;
                        state_d      = StHold;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_pc    = hold_pc_q;
                    deliver_instr = hold_instr_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush) begin
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP;
        end else if (!stall) begin
            if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = deliver_pc;
                ifid_instr_d = deliver_instr;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            kill_q       <= 1'b0;
            req_pc_q     <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_rv32_fetch.sv
// Scoreboard bench for rv32_fetch: directed PC/flush/stall/halt stimulus, a reactive
// instruction memory, and a monitor that checks every valid IF/ID load against a queue.
module tb_rv32_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        flush;
    logic        halt;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        busy;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    logic        gnt_en;
    int          lat;
    int          checks;
    int          errors;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    rv32_fetch #(.NOP(NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .flush      (flush),
        .halt       (halt),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .busy       (busy),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt = imem_req & gnt_en;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'd0) return 32'h0000_000A;
        if (a == 32'd8) return 32'h0000_000B;
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = data_of(p);
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: grant is immediate; rvalid arrives lat cycles after the grant cycle.
    logic        fire;
    logic [31:0] faddr;
    logic        pending;
    logic [31:0] paddr;
    int          cnt;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pending     = 1'b0;
        paddr       = 32'h0;
        cnt         = 0;
        forever begin
            @(negedge clk);
            fire  = imem_req & imem_gnt;
            faddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (fire) begin
                pending = 1'b1;
                paddr   = faddr;
                cnt     = lat;
            end
            if (pending) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = data_of(paddr);
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // A valid IF/ID after an edge with no stall/flush is a fresh load and must match the queue.
    logic prev_ok;
    initial begin
        exp_t e;
        prev_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ok && ifid_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected no instruction",
                             ifid_pc, ifid_instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", ifid_pc, e.pc);
                    chk("sb_instr", ifid_instr, e.instr);
                end
            end
            prev_ok = rst_n && !stall && !flush;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int delivered;
        int reqs;
        logic adv;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; pc = 32'h0; halt = 1'b0; flush = 1'b0; stall = 1'b0;
        gnt_en = 1'b1; lat = 1;

        // Reset values
        settle();
        chk("rst_req", imem_req, 0);
        chk("rst_busy", busy, 1);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_pc", ifid_pc, 0);
        chk("rst_instr", ifid_instr, NOP);

        // First fetch, 1-cycle memory
        step(); rst_n = 1'b1; push(32'd0);
        settle();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_busy_req", busy, 1);
        step(); halt = 1'b1;
        settle();
        chk("t1_busy_rv", busy, 0);
        step();
        settle();
        chk("t1_valid", ifid_valid, 1);
        chk("t1_req_halt", imem_req, 0);
        step();

        // Sequential fetch of pc 0..3, 3-cycle latency
        pc = 32'd0; halt = 1'b0; lat = 3;
        for (int k = 0; k < 4; k++) push(k);
        delivered = 0; reqs = 0;
        for (int c = 0; c < 60; c++) begin
            settle();
            if (imem_req) reqs++;
            adv = !busy;
            if (adv) delivered++;
            step();
            if (adv) pc = pc + 32'd1;
            if (delivered == 4) break;
        end
        halt = 1'b1;
        chk("t2_delivered", delivered, 4);
        chk("t2_reqs", reqs, 4);

        // Flush during WAIT: old pc 5, target 20
        pc = 32'd5; halt = 1'b0; lat = 3;
        settle();
        chk("t3_addr5", imem_addr, 5);
        step(); flush = 1'b1; pc = 32'd20;
        settle();
        chk("t3_busy_flush", busy, 1);
        step(); flush = 1'b0;
        settle();
        chk("t3_valid_after_flush", ifid_valid, 0);
        chk("t3_no_req_wait", imem_req, 0);
        step();
        settle();
        chk("t3_busy_drop", busy, 1);
        step(); push(32'd20);
        settle();
        chk("t3_req20", imem_req, 1);
        chk("t3_addr20", imem_addr, 20);
        step(); halt = 1'b1;
        step();
        step();
        settle();
        chk("t3_busy_deliver", busy, 0);
        step();
        settle();
        chk("t3_ifid_pc", ifid_pc, 20);
        step();

        // Flush and rvalid in the same cycle
        pc = 32'd30; halt = 1'b0; lat = 1;
        settle();
        step(); flush = 1'b1; pc = 32'd40;
        settle();
        chk("t4_busy_drop", busy, 1);
        step(); flush = 1'b0; push(32'd40);
        settle();
        chk("t4_req40", imem_req, 1);
        chk("t4_addr40", imem_addr, 40);
        chk("t4_valid", ifid_valid, 0);
        chk("t4_instr_nop", ifid_instr, NOP);
        chk("t4_pc0", ifid_pc, 0);
        step(); halt = 1'b1;
        settle();
        chk("t4_busy_deliver", busy, 0);
        step();
        settle();
        chk("t4_ifid_pc", ifid_pc, 40);
        step();

        // Stall when rvalid arrives: pc 8, rdata 0xB, held 3 cycles
        pc = 32'd8; halt = 1'b0; lat = 1; push(32'd8);
        settle();
        step(); stall = 1'b1; halt = 1'b1;
        settle();
        chk("t5_busy_s1", busy, 1);
        step();
        settle();
        chk("t5_busy_s2", busy, 1);
        chk("t5_valid_s2", ifid_valid, 0);
        step();
        settle();
        chk("t5_busy_s3", busy, 1);
        chk("t5_pc_s3", ifid_pc, 40);
        step(); stall = 1'b0;
        settle();
        chk("t5_busy_release", busy, 0);
        step();
        settle();
        chk("t5_valid", ifid_valid, 1);
        chk("t5_instr", ifid_instr, 32'h0000_000B);
        step();

        // Flush during HOLD discards the buffer
        pc = 32'd50; halt = 1'b0; lat = 1;
        settle();
        step(); stall = 1'b1; halt = 1'b1;
        settle();
        step(); flush = 1'b1; pc = 32'd60;
        settle();
        chk("t5h_busy_flush", busy, 1);
        step(); flush = 1'b0; stall = 1'b0;
        settle();
        chk("t5h_valid", ifid_valid, 0);
        chk("t5h_pc0", ifid_pc, 0);
        chk("t5h_req_halt", imem_req, 0);
        step();
        settle();
        chk("t5h_busy_after", busy, 1);
        step();

        // Halt in IDLE, then halt rising in WAIT
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t6_req_halted", imem_req, 0);
            step();
        end
        pc = 32'd70; halt = 1'b0; lat = 3; push(32'd70);
        settle();
        chk("t6_req70", imem_req, 1);
        step(); halt = 1'b1;
        settle();
        chk("t6_req_wait", imem_req, 0);
        step();
        step();
        settle();
        chk("t6_busy_deliver", busy, 0);
        step();
        settle();
        chk("t6_ifid_pc", ifid_pc, 70);
        chk("t6_req_after", imem_req, 0);
        step();
        settle();
        chk("t6_req_after2", imem_req, 0);
        step();

        // Reset mid-request; the late rvalid must be ignored
        pc = 32'd80; halt = 1'b0; lat = 2;
        settle();
        step(); rst_n = 1'b0;
        settle();
        chk("t7_req_in_reset", imem_req, 0);
        chk("t7_instr_reset", ifid_instr, NOP);
        step(); rst_n = 1'b1; halt = 1'b1;
        settle();
        chk("t7_busy_late_rv", busy, 1);
        step();
        settle();
        chk("t7_valid", ifid_valid, 0);
        step();

        repeat (3) step();
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32_fetch.md
# rv32_fetch

Instruction fetch stage and IF/ID pipeline register for the 5-stage RV32 core, sitting directly downstream of the program counter unit. It takes the current word-addressed PC, issues one request at a time to instruction memory over a req/gnt/rvalid handshake, and delivers the returned instruction with its PC to the decode stage. It back-pressures the PC unit through `busy` and squashes wrong-path fetches on `flush`.

## Interface
- `NOP`, default 32'h0000_0013, instruction word loaded into IF/ID on reset and on flush (addi x0,x0,0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  in  32  current word-addressed PC from the PC unit.
- `flush`  in  1  from the PC unit: redirect taken; current `pc` is already the target.
- `halt`  in  1  from the PC unit: no new fetches may be issued.
- `stall`  in  1  from the hazard unit: decode cannot accept; IF/ID must hold.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address, equal to `pc`.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  response valid, at least 1 cycle after `imem_gnt`.
- `imem_rdata`  in  32  response instruction word.
- `busy`  out  1  to the PC unit: PC must not advance this cycle.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_pc`  out  32  PC of the instruction in IF/ID.
- `ifid_instr`  out  32  instruction in IF/ID.

## Operation
- FSM states: IDLE (no outstanding request), WAIT (one request granted, response pending), HOLD (response captured in hold buffer, decode stalled).
- Additional state: `kill` flag (outstanding request is wrong-path); 64-bit hold buffer {pc, instr}.
- IDLE: `imem_req = ~halt`, `imem_addr = pc`. On `imem_req & imem_gnt`, go to WAIT, latch `pc` as request PC.
- WAIT, `imem_rvalid` and (`kill` or `flush`): drop response, clear `kill`, go to IDLE.
- WAIT, `imem_rvalid`, not killed, `stall=0`: load IF/ID {valid=1, request PC, `imem_rdata`}, go to IDLE.
- WAIT, `imem_rvalid`, not killed, `stall=1`: capture in hold buffer, go to HOLD.
- WAIT, `flush` without `imem_rvalid`: set `kill`, stay in WAIT.
- HOLD, `flush`: discard buffer, go to IDLE. HOLD, `stall=0`: move buffer into IF/ID, go to IDLE.
- `busy` = 0 only in the cycle an instruction is loaded into IF/ID (from WAIT or HOLD); 1 otherwise, including the cycle a response is dropped.
- IF/ID: `flush` has priority and loads {0, 0, NOP} regardless of `stall`. Otherwise `stall=1` holds it. Otherwise it loads the delivered instruction, or {0, unchanged pc, NOP} when none is delivered.
- `halt` only gates new requests. An outstanding request completes normally.
- Flush in IDLE with a same-cycle grant is valid, not killed, because `pc` is already the target.
- At most one outstanding request. `imem_addr` is a 32-bit word address with no alignment checks.

## Timing
- Reset: state=IDLE, `kill`=0, `imem_req`=0 while reset is asserted, `busy`=1, `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=NOP. Reset mid-request abandons it, and any later `imem_rvalid` in IDLE is ignored.
- `imem_req`, `imem_addr` and `busy` are combinational from state and inputs. IF/ID outputs are registered.
- Memory with 1-cycle response: grant in cycle N, rvalid in N+1, IF/ID valid in N+2, PC advances at the N+1 edge. Peak throughput is 1 instruction per 2 cycles.
- `flush` is a single-cycle pulse. A wrong-path instruction never reaches IF/ID with `ifid_valid`=1.

## Test plan
- Reset release, `pc`=0, memory gnt immediate, rvalid +1 with rdata=32'hA -> IF/ID {1, 0, 32'hA} two cycles after req; `busy`=0 exactly in the rvalid cycle.
- Sequential fetch of pc 0..3 with a 3-cycle response latency -> four valid IF/ID entries in order; `busy` low once per instruction; no second req while in WAIT.
- Flush during WAIT (old pc 5, target 20) -> response for 5 dropped, `ifid_valid`=0; next req at addr 20; IF/ID later {1, 20, data}.
- Flush and rvalid in the same cycle -> response dropped, `busy`=1, IF/ID = NOP invalid, next req at new `pc`.
- `stall`=1 when rvalid arrives (pc 8, rdata 32'hB) for 3 cycles -> IF/ID unchanged, `busy`=1; stall drops -> IF/ID {1, 8, 32'hB} and `busy`=0 in that cycle. Flush during HOLD -> buffer discarded.
- `halt`=1 in IDLE -> `imem_req`=0 indefinitely. `halt` rises in WAIT -> outstanding response still delivered, then no new req.
